// File: rtl/fpu_stream_ctrl.sv
// fpu_stream_ctrl: in-order issue stage in front of a combinational bfloat16 fpu.
// Requests are queued in a small FIFO whose head feeds the fpu. The fpu result is
// captured into a single output slot with a valid/ready handshake. A sticky overflow
// flag and a wrapping result counter report delivered traffic.
module fpu_stream_ctrl #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MODE_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      clr_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [MODE_WIDTH-1:0]     in_op_i,
    input  logic [DATA_WIDTH-1:0]     in_a_i,
    input  logic [DATA_WIDTH-1:0]     in_b_i,
    output logic [MODE_WIDTH-1:0]     fpu_op_o,
    output logic [DATA_WIDTH-1:0]     fpu_in1_o,
    output logic [DATA_WIDTH-1:0]     fpu_in2_o,
    input  logic [DATA_WIDTH-1:0]     fpu_out_i,
    input  logic                      fpu_overflow_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic                      out_overflow_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      ovf_sticky_o,
    output logic [CNT_WIDTH-1:0]      res_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Request storage; contents are only meaningful between the pointers, so no reset.
    logic [MODE_WIDTH-1:0] op_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] a_mem_r  [DEPTH];
    logic [DATA_WIDTH-1:0] b_mem_r  [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic [LVL_W-1:0]      level_nxt_s;

    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_ovf_r;
    logic                  ovf_sticky_r;
    logic [CNT_WIDTH-1:0]  res_cnt_r;

    logic                  full_s;
    logic                  push_s;
    logic                  slot_free_s;
    logic                  issue_s;
    logic                  deliver_s;

    // Handshake decode: push into FIFO, issue head into slot, deliver slot downstream.
    always_comb begin
        full_s      = (level_r == FULL_LVL);
        push_s      = in_valid_i & ~full_s;
        slot_free_s = ~out_valid_r | out_ready_i;
        issue_s     = (level_r != {LVL_W{1'b0}}) & slot_free_s;
        deliver_s   = out_valid_r & out_ready_i;
    end

    // Occupancy next value; a simultaneous push and issue leaves it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, issue_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Write accepted requests at the tail; a flushed push is simply never read.
    always_ff @(posedge clk_i) begin
        if (push_s && !flush_i) begin
            op_mem_r[wr_ptr_r] <= in_op_i;
            a_mem_r[wr_ptr_r]  <= in_a_i;
            b_mem_r[wr_ptr_r]  <= in_b_i;
        end
    end

    // FIFO pointers and level; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
        end
    end

    // Output slot: capture fpu result on issue, empty on a drain-only delivery.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_ovf_r   <= 1'b0;
        end else if (flush_i) begin
            out_valid_r <= 1'b0;
        end else if (issue_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= fpu_out_i;
            out_ovf_r   <= fpu_overflow_i;
        end else if (deliver_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Status: clear wins over a same-cycle delivery; flush suppresses counting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_cnt_r    <= {CNT_WIDTH{1'b0}};
            ovf_sticky_r <= 1'b0;
        end else if (clr_i) begin
            res_cnt_r    <= {CNT_WIDTH{1'b0}};
            ovf_sticky_r <= 1'b0;
        end else if (deliver_s && !flush_i) begin
            res_cnt_r    <= res_cnt_r + CNT_WIDTH'(1);
            ovf_sticky_r <= ovf_sticky_r | out_ovf_r;
        end
    end

    assign in_ready_o     = ~full_s;
    assign level_o        = level_r;
    assign fpu_op_o       = op_mem_r[rd_ptr_r];
    assign fpu_in1_o      = a_mem_r[rd_ptr_r];
    assign fpu_in2_o      = b_mem_r[rd_ptr_r];
    assign out_valid_o    = out_valid_r;
    assign out_data_o     = out_data_r;
    assign out_overflow_o = out_ovf_r;
    assign ovf_sticky_o   = ovf_sticky_r;
    assign res_cnt_o      = res_cnt_r;

endmodule

// File: tb/tb_fpu_stream_ctrl.sv
// Testbench for fpu_stream_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fpu_stream_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op = 2'd0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;

    logic        in_ready;
    logic [1:0]  fpu_op;
    logic [15:0] fpu_in1, fpu_in2, fpu_out;
    logic        fpu_ovf;
    logic        out_valid, out_ovf, sticky;
    logic [15:0] out_data, res_cnt;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Stand-in fpu: exact results for the directed bfloat16 cases, a fixed mix otherwise.
    function automatic logic [16:0] fpu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op == 2'd0 && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
        if (op == 2'd2 && a == 16'h7F00 && b == 16'h7F00) return {1'b1, 16'h7F80};
        return {(op == 2'd2) && a[14] && b[14], a ^ {b[7:0], b[15:8]} ^ {14'd0, op}};
    endfunction

    assign {fpu_ovf, fpu_out} = fpu_fn(fpu_op, fpu_in1, fpu_in2);

    fpu_stream_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(16), .MODE_WIDTH(2), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b),
        .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
        .fpu_out_i(fpu_out), .fpu_overflow_i(fpu_ovf),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_overflow_o(out_ovf), .level_o(level), .ovf_sticky_o(sticky), .res_cnt_o(res_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [1:0] op; logic [15:0] a; logic [15:0] b; } req_t;
    req_t        m_q[$];
    bit          m_valid;
    logic [15:0] m_data;
    bit          m_ovf;
    logic [15:0] m_cnt;
    bit          m_sticky;
    bit          t_dlv, t_iss, t_psh, t_old_ovf;
    logic [16:0] t_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_valid = 1'b0; m_data = 16'd0; m_ovf = 1'b0; m_cnt = 16'd0; m_sticky = 1'b0;
        end else begin
            t_dlv     = m_valid && out_ready;
            t_iss     = (m_q.size() != 0) && (!m_valid || out_ready);
            t_psh     = in_valid && (m_q.size() < DEPTH);
            t_old_ovf = m_ovf;
            if (flush) begin
                m_q.delete();
                m_valid = 1'b0;
            end else begin
                if (t_iss) begin
                    t_res = fpu_fn(m_q[0].op, m_q[0].a, m_q[0].b);
                    void'(m_q.pop_front());
                    m_data = t_res[15:0]; m_ovf = t_res[16]; m_valid = 1'b1;
                end else if (t_dlv) begin
                    m_valid = 1'b0;
                end
                if (t_psh) m_q.push_back('{op: in_op, a: in_a, b: in_b});
            end
            if (clr) begin
                m_cnt = 16'd0; m_sticky = 1'b0;
            end else if (t_dlv && !flush) begin
                m_cnt = m_cnt + 16'd1;
                m_sticky = m_sticky | t_old_ovf;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_level", 32'(level), 32'(m_q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("m_out_data", 32'(out_data), 32'(m_data));
                chk("m_out_ovf", 32'(out_ovf), 32'(m_ovf));
            end
            chk("m_res_cnt", 32'(res_cnt), 32'(m_cnt));
            chk("m_sticky", 32'(sticky), 32'(m_sticky));
            if (m_q.size() != 0) begin
                chk("m_head_op", 32'(fpu_op), 32'(m_q[0].op));
                chk("m_head_a", 32'(fpu_in1), 32'(m_q[0].a));
                chk("m_head_b", 32'(fpu_in2), 32'(m_q[0].b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit done;
        // Reset
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_cnt", 32'(res_cnt), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cmp_en = 1'b1;

        // 1: single ADD, latency
        out_ready = 1'b1;
        set_req(2'd0, 16'h3F80, 16'h4000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h4040);
        step();
        @(negedge clk);
        chk("t1_cnt", 32'(res_cnt), 32'd1);

        // 2: back-pressure with 5 requests
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(2'd1, 16'h1000 + 16'(i), 16'h0010 * 16'(i));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_slot_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            @(negedge clk);
            if (!out_valid && level == 3'd0) done = 1'b1;
        end
        chk("t2_drain_done", 32'(done), 32'd1);
        chk("t2_cnt", 32'(res_cnt), 32'd6);

        // 3: overflow, sticky, clear beating a same-cycle delivery
        out_ready = 1'b0;
        set_req(2'd2, 16'h7F00, 16'h7F00);
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_ovf", 32'(out_ovf), 32'd1);
        chk("t3_sticky_before", 32'(sticky), 32'd0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t3_sticky", 32'(sticky), 32'd1);
        chk("t3_cnt", 32'(res_cnt), 32'd7);
        set_req(2'd0, 16'h0001, 16'h0002);
        step();
        in_valid = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("t3_clr_cnt", 32'(res_cnt), 32'd0);
        chk("t3_clr_sticky", 32'(sticky), 32'd0);
        chk("t3_clr_valid", 32'(out_valid), 32'd0);

        // 4: streaming, one result per cycle, pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_req(2'(i), 16'h2000 + 16'(i * 3), 16'h0F0F ^ 16'(i));
            step();
            @(negedge clk);
            chk("t4_level_le1", 32'(level <= 3'd1), 32'd1);
            if (i >= 1) chk("t4_valid_each", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("t4_cnt", 32'(res_cnt), 32'd20);

        // 5: flush with level 3 and full slot, racing push and delivery
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(2'd3, 16'h5000 + 16'(i), 16'h0A0A);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pre_level", 32'(level), 32'd3);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        set_req(2'd0, 16'h1111, 16'h2222);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_cnt", 32'(res_cnt), 32'd20);

        // 6: asynchronous reset mid-stream
        out_ready = 1'b1;
        set_req(2'd2, 16'h7F00, 16'h7F00);
        step();
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(2'd1, 16'h6000 + 16'(i), 16'h0003);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_pre_level", 32'(level), 32'd2);
        chk("t6_pre_sticky", 32'(sticky), 32'd1);
        chk("t6_pre_cnt", 32'(res_cnt), 32'd21);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_ovf", 32'(out_ovf), 32'd0);
        chk("t6_rst_sticky", 32'(sticky), 32'd0);
        chk("t6_rst_cnt", 32'(res_cnt), 32'd0);
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_req(2'd0, 16'h3F80, 16'h4000);
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t6_post_valid", 32'(out_valid), 32'd1);
        chk("t6_post_data", 32'(out_data), 32'h4040);
        chk("t6_post_in_ready", 32'(in_ready), 32'd1);
        step();
        @(negedge clk);
        chk("t6_post_cnt", 32'(res_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
